// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared constants and types for the pipeline flow controller.
// This covers the redirect select codes, the MDU sequencer states and the default exception base.
package pipe_pkg;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_EXC = 2'd1;
  localparam logic [1:0] NPC_EPC = 2'd2;

  localparam int          BUSY_CNT_W    = 4;
  localparam logic [31:0] EBASE_DEFAULT = 32'h0000_4180;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// Bundle of hazard/exception requests into the flow controller and the stage controls it returns.
// The master side is the pipeline datapath and the slave side is the controller.
interface pipe_flow_ctrl_if;
  logic        D_data_stall;
  logic        D_is_mdu;
  logic        E_mdu_start;
  logic        E_mdu_is_div;
  logic        exc_req;
  logic        M_is_eret;
  logic [31:0] EPC;

  logic        F_en;
  logic        D_en;
  logic        E_flush;
  logic        req;
  logic        eret_flush;
  logic [1:0]  npc_sel;
  logic [31:0] npc_redirect;
  logic        mdu_busy;
  logic        mdu_start_ok;
  logic [3:0]  busy_cnt;

  modport master (
    output D_data_stall, D_is_mdu, E_mdu_start, E_mdu_is_div, exc_req, M_is_eret, EPC,
    input  F_en, D_en, E_flush, req, eret_flush, npc_sel, npc_redirect,
           mdu_busy, mdu_start_ok, busy_cnt
  );

  modport slave (
    input  D_data_stall, D_is_mdu, E_mdu_start, E_mdu_is_div, exc_req, M_is_eret, EPC,
    output F_en, D_en, E_flush, req, eret_flush, npc_sel, npc_redirect,
           mdu_busy, mdu_start_ok, busy_cnt
  );
endinterface

// File: rtl/pipe_flow_ctrl_mdu_busy_seq.sv
// MDU busy sequencer: an accepted start loads the op latency, and the counter then runs down to idle.
module mdu_busy_seq
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mdu_start_ok,
  input  logic                  is_div,
  output logic                  mdu_busy,
  output logic [BUSY_CNT_W-1:0] busy_cnt
);

  mdu_state_e            state_q, state_d;
  logic [BUSY_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Once the counter runs, it keeps running through exceptions, because an older instruction owns the unit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MDU_IDLE: begin
        if (mdu_start_ok) begin
          state_d = MDU_BUSY;
          cnt_d   = is_div ? BUSY_CNT_W'(DIV_CYCLES) : BUSY_CNT_W'(MULT_CYCLES);
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == BUSY_CNT_W'(1)) state_d = MDU_IDLE;
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mdu_busy = (state_q == MDU_BUSY);
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: stage enables and flushes, redirect PC and MDU structural stall.
// The priority order is exception, then eret, then stall, then normal flow.
module pipe_flow_ctrl
  import pipe_pkg::*;
#(
  parameter int          MULT_CYCLES = 5,
  parameter int          DIV_CYCLES  = 10,
  parameter logic [31:0] EBASE       = EBASE_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  pipe_flow_ctrl_if.slave fc
);

  if (MULT_CYCLES < 1 || MULT_CYCLES > 15 || DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_cfg
    $error("pipe_flow_ctrl: MULT_CYCLES/DIV_CYCLES must be in 1..15");
  end

  logic req_any;
  logic stall;

  assign req_any         = fc.exc_req | fc.M_is_eret;
  assign fc.mdu_start_ok = fc.E_mdu_start & ~req_any;

  mdu_busy_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_seq (
    .clk          (clk),
    .reset        (reset),
    .mdu_start_ok (fc.mdu_start_ok),
    .is_div       (fc.E_mdu_is_div),
    .mdu_busy     (fc.mdu_busy),
    .busy_cnt     (fc.busy_cnt)
  );

  // A D-stage MDU op also waits when a start is issuing from E in the same cycle.
  assign stall = ~req_any &
                 (fc.D_data_stall | (fc.D_is_mdu & (fc.mdu_busy | fc.E_mdu_start)));

  assign fc.F_en       = ~stall;
  assign fc.D_en       = ~stall;
  assign fc.E_flush    = stall;
  assign fc.req        = fc.exc_req;
  assign fc.eret_flush = fc.M_is_eret & ~fc.exc_req;

  always_comb begin
    fc.npc_sel      = NPC_SEQ;
    fc.npc_redirect = '0;
    if (fc.exc_req) begin
      fc.npc_sel      = NPC_EXC;
      fc.npc_redirect = EBASE;
    end else if (fc.M_is_eret) begin
      fc.npc_sel      = NPC_EPC;
      fc.npc_redirect = fc.EPC;
    end
  end

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
- Central flow controller for the five-stage pipeline.
- Generates the per-stage enable and flush controls consumed by the F/D, D/E, E/M and M/W pipeline registers.
- Owns the multiply/divide busy sequencer.
- Resolves priority between exception entry, eret return, MDU structural stalls and data-hazard stalls, and supplies the redirect PC to the fetch stage.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.
- EBASE, 32'h0000_4180, exception handler entry PC.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- D_data_stall  in  1  Tuse/Tnew hazard stall request from the hazard comparator.
- D_is_mdu  in  1  instruction in D uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- E_mdu_start  in  1  mult/div instruction in E this cycle.
- E_mdu_is_div  in  1  qualifies E_mdu_start: 1 = div/divu.
- exc_req  in  1  CP0 exception/interrupt request for the instruction in M.
- M_is_eret  in  1  eret in M.
- EPC  in  32  CP0 EPC.
- F_en  out  1  PC register enable.
- D_en  out  1  F/D register enable.
- E_flush  out  1  insert bubble into D/E.
- req  out  1  broadcast flush of all pipeline registers (exception entry).
- eret_flush  out  1  broadcast flush for eret return.
- npc_sel  out  2  0 = sequential/branch, 1 = EBASE, 2 = EPC.
- npc_redirect  out  32  redirect target.
- mdu_busy  out  1  MDU busy.
- mdu_start_ok  out  1  qualified MDU start; MDU latches operands only on this.
- busy_cnt  out  4  remaining MDU busy cycles (debug/verification).

Behaviour:
- Reset (reset=0, asynchronous):
  - busy_cnt=0, mdu_busy=0, state=IDLE.
  - Combinational outputs settle to F_en=1, D_en=1, E_flush=0, req=0, eret_flush=0, npc_sel=0, npc_redirect=0.
- MDU sequencer FSM, states IDLE and BUSY:
  - mdu_start_ok = E_mdu_start & ~exc_req & ~M_is_eret.
  - IDLE with mdu_start_ok: go to BUSY next edge; busy_cnt loads DIV_CYCLES if E_mdu_is_div, else MULT_CYCLES.
  - BUSY: busy_cnt decrements by 1 per cycle. Leaves to IDLE on the edge where busy_cnt==1, so busy_cnt==0 in IDLE.
  - mdu_busy = (state==BUSY).
  - Exception or eret during BUSY does not abort the count: an instruction older than M already owns the MDU.
  - mdu_start_ok while BUSY cannot occur, because the stall rule below prevents it. The bench asserts this; the RTL ignores it.
- Stall, combinational: stall = ~req_any & (D_data_stall | (D_is_mdu & (mdu_busy | E_mdu_start))).
  - On stall: F_en=0, D_en=0, E_flush=1.
- Exception, highest priority:
  - exc_req=1 gives req=1, npc_sel=1, npc_redirect=EBASE, F_en=1, D_en=1, E_flush=0, eret_flush=0.
  - The pipeline registers load their bubble/EBASE values on the same edge.
- Eret, second priority:
  - M_is_eret=1 with exc_req=0 gives eret_flush=1, npc_sel=2, npc_redirect=EPC, F_en=1, D_en=1, E_flush=0.
- req_any = exc_req | M_is_eret. Priority order: exc_req > M_is_eret > stall > normal.
- Simultaneous exc_req and E_mdu_start: the start is squashed; the FSM stays IDLE.
- Redirect latency: zero cycles. Redirect outputs are combinational from M-stage inputs.
- busy_cnt width 4: both parameters must be ≤15; elaboration-time check.
- Reset asserted mid-BUSY: counter clears immediately; mdu_busy drops asynchronously.

Decomposition:
- Shared package (pipe_pkg):
  - NPC_SEQ=2'd0, NPC_EXC=2'd1, NPC_EPC=2'd2.
  - MDU state encodings IDLE=1'b0, BUSY=1'b1.
  - EBASE default constant.
- One sub-module, mdu_busy_seq: the IDLE/BUSY FSM and counter. Inputs: mdu_start_ok, is_div. Outputs: mdu_busy, busy_cnt.
- Priority and stall logic stays in pipe_flow_ctrl.

Test Plan:
- Reset release then E_mdu_start=1, E_mdu_is_div=0 for one cycle -> mdu_busy high for exactly 5 cycles; busy_cnt 5,4,3,2,1 then 0.
- Div start, then D_is_mdu=1 held -> F_en=D_en=0 and E_flush=1 for all 10 busy cycles (plus the start cycle); released on the cycle mdu_busy falls.
- exc_req=1 with E_mdu_start=1, D_data_stall=1 -> mdu_start_ok=0, req=1, npc_redirect=32'h0000_4180, F_en=1, E_flush=0; FSM stays IDLE.
- M_is_eret=1, EPC=32'h0000_3010, D_data_stall=1 -> eret_flush=1, npc_sel=2, npc_redirect=32'h0000_3010, no stall.
- exc_req=1 and M_is_eret=1 together -> req=1, eret_flush=0, npc_sel=1.
- Reset pulsed low at busy_cnt=6 of a div -> busy_cnt=0 and mdu_busy=0 before the next clk edge.
